down_counter: RTL and testbench

Loadable down-counter / interval timer, the count-down counterpart of the team's free-running up counter. Software or upstream logic loads a start value. The block then decrements once per enabled clock and flags the terminal count with a one-cycle pulse. It sits beside the up counter in the counter library and serves as a timeout/interval source for control FSMs.

---
 rtl/down_counter_pkg.sv | 12 +
 rtl/down_counter.sv | 113 +++++++++++
 tb/tb_down_counter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/down_counter_pkg.sv
// Shared definitions for the counter library: state encodings and the default width.
package down_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter / interval timer with a registered one-cycle terminal-count pulse.
// Define DOWN_COUNTER_RELOAD_EN for auto-reload mode; otherwise DONE is terminal (one-shot).
module down_counter
    import down_counter_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] out,
    output logic         tc,
    output logic         busy
);

    localparam logic [N-1:0] CNT_ZERO = N'(0);
    localparam logic [N-1:0] CNT_ONE  = N'(1);

    state_t       state_r;
    state_t       state_nxt_s;
    logic [N-1:0] out_r;
    logic [N-1:0] out_nxt_s;
    logic         tc_r;
    logic         tc_nxt_s;
    logic         busy_r;
    logic         busy_nxt_s;
`ifdef DOWN_COUNTER_RELOAD_EN
    logic [N-1:0] reload_r;
    logic [N-1:0] reload_nxt_s;
`endif

    // Next-state and next-output logic; load beats enable, rst is applied in the register block.
    always_comb begin
        state_nxt_s = state_r;
        out_nxt_s   = out_r;
        tc_nxt_s    = 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
        reload_nxt_s = reload_r;
`endif
        if (load) begin
            out_nxt_s   = load_val;
            state_nxt_s = (load_val != CNT_ZERO) ? ST_RUN : ST_DONE;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload_nxt_s = load_val;
`endif
        end else if (enable) begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_RUN: begin
                    if (out_r > CNT_ONE) begin
                        out_nxt_s = out_r - CNT_ONE;
                    end else if (out_r == CNT_ONE) begin
                        out_nxt_s   = CNT_ZERO;
                        state_nxt_s = ST_DONE;
                        tc_nxt_s    = 1'b1;
                    end else begin
                        // Zero in RUN cannot be reached; settle in DONE without a pulse.
                        state_nxt_s = ST_DONE;
                    end
                end
                ST_DONE: begin
`ifdef DOWN_COUNTER_RELOAD_EN
                    if (reload_r != CNT_ZERO) begin
                        out_nxt_s   = reload_r;
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
`else
                    state_nxt_s = ST_DONE;
`endif
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    out_nxt_s   = CNT_ZERO;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
        busy_nxt_s = (state_nxt_s == ST_RUN) ? 1'b1 : 1'b0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            out_r   <= CNT_ZERO;
            tc_r    <= 1'b0;
            busy_r  <= 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload_r <= CNT_ZERO;
`endif
        end else begin
            state_r <= state_nxt_s;
            out_r   <= out_nxt_s;
            tc_r    <= tc_nxt_s;
            busy_r  <= busy_nxt_s;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload_r <= reload_nxt_s;
`endif
        end
    end

    assign out  = out_r;
    assign tc   = tc_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed scenarios followed by random stimulus,
// compared every cycle against a count-based reference model.
module tb_down_counter;

    localparam int N = 4;
`ifdef DOWN_COUNTER_RELOAD_EN
    localparam bit RELOAD_MODE = 1'b1;
`else
    localparam bit RELOAD_MODE = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         enable;
    logic         load;
    logic [N-1:0] load_val;
    logic [N-1:0] out;
    logic         tc;
    logic         busy;

    int errors = 0;
    int checks = 0;

    // Reference model: remaining count, remembered start value, pulse flag.
    int m_cnt    = 0;
    int m_reload = 0;
    bit m_tc     = 1'b0;

    down_counter #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .load     (load),
        .load_val (load_val),
        .out      (out),
        .tc       (tc),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare just after it.
    task automatic step(input logic r, input logic l, input logic [N-1:0] v, input logic e);
        rst      = r;
        load     = l;
        load_val = v;
        enable   = e;
        @(posedge clk);
        if (r) begin
            m_cnt    = 0;
            m_reload = 0;
            m_tc     = 1'b0;
        end else if (l) begin
            m_cnt    = int'(v);
            m_reload = int'(v);
            m_tc     = 1'b0;
        end else if (e && m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            m_tc  = (m_cnt == 0);
        end else if (e && RELOAD_MODE && m_reload != 0) begin
            m_cnt = m_reload;
            m_tc  = 1'b0;
        end else begin
            m_tc = 1'b0;
        end
        #1;
        check_value("out",  32'(out),  32'(m_cnt));
        check_value("tc",   32'(tc),   32'(m_tc));
        check_value("busy", 32'(busy), (m_cnt != 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        load_val = 4'd0;
        enable   = 1'b0;

        // Reset with enable high, then enable ignored while idle.
        for (int i = 0; i < 4; i++)  step(1'b1, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'd0, 1'b1);

        // Basic count from 5.
        step(1'b0, 1'b1, 4'd5, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'd0, 1'b1);

        // Pause at 3, then resume.
        step(1'b0, 1'b1, 4'd5, 1'b0);
        for (int i = 0; i < 2; i++)  step(1'b0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++)  step(1'b0, 1'b0, 4'd0, 1'b1);

        // Load of zero never pulses.
        step(1'b0, 1'b1, 4'd0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'd0, 1'b1);

        // Load 15 while running at 2.
        step(1'b0, 1'b1, 4'd9, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b0, 1'b1, 4'hF, 1'b1);

        // Load coinciding with the 1-to-0 step wins, no pulse.
        step(1'b0, 1'b1, 4'd2, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b0, 1'b1, 4'd7, 1'b1);

        // Reset mid-count at 6.
        step(1'b0, 1'b1, 4'd8, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b1, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'd0, 1'b1);

        // Load 3 with enable held: periodic or one-shot depending on build.
        step(1'b0, 1'b1, 4'd3, 1'b1);
        for (int i = 0; i < 23; i++) step(1'b0, 1'b0, 4'd0, 1'b1);

        // Random traffic, biased toward small start values so expiries are frequent.
        for (int i = 0; i < 2000; i++) begin
            logic         r_s;
            logic         l_s;
            logic         e_s;
            logic [N-1:0] v_s;
            r_s = ($urandom_range(0, 49) == 0);
            l_s = ($urandom_range(0, 7) == 0);
            e_s = ($urandom_range(0, 3) != 0);
            v_s = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : N'($urandom_range(0, 4));
            step(r_s, l_s, v_s, e_s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
